// File: rtl/fx_pkg.sv
// Shared Q-format definitions for the fixed-point arithmetic blocks
// (saturating multiplier and sequential divider).
package fx_pkg;

  localparam int FX_N     = 12;
  localparam int FX_DECIM = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    SAT,
    DONE
  } div_state_t;

  function automatic int SAT_MAX(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

  // Symmetric saturation: the most negative code is never produced.
  function automatic int SAT_MIN(input int n);
    return -SAT_MAX(n);
  endfunction

endpackage

// File: rtl/divisor_secuencial_div_paso.sv
// Single combinational restoring-division step: shift in one dividend bit,
// subtract the divisor when it fits.
module div_paso
  import fx_pkg::*;
#(
  parameter int N = FX_N
) (
  input  logic [N:0]   r,
  input  logic         d_bit,
  input  logic [N-1:0] mag_b,
  output logic [N:0]   r_next,
  output logic         q_bit
);

  logic [N+1:0] r_sh;
  logic [N+1:0] b_ext;

  always_comb begin
    r_sh  = {r, d_bit};
    b_ext = {2'b00, mag_b};
    if (r_sh >= b_ext) begin
      // Remainder stays below mag_b, so the truncation loses nothing.
      r_next = (N+1)'(r_sh - b_ext);
      q_bit  = 1'b1;
    end else begin
      r_next = r_sh[N:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential signed fixed-point restoring divider, one quotient bit per clock,
// with start/busy/done handshake and symmetric saturation.
module divisor_secuencial
  import fx_pkg::*;
#(
  parameter int N     = FX_N,
  parameter int DECIM = FX_DECIM
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] ResulDiv,
  output logic         done,
  output logic         busy,
  output logic         div_zero
);

  localparam int W  = N + DECIM;
  localparam int CW = $clog2(W);

  localparam logic [N-1:0] SAT_MAX_N = N'(SAT_MAX(N));
  localparam logic [N-1:0] SAT_MIN_N = N'(SAT_MIN(N));
  localparam logic [W-1:0] SAT_MAX_W = W'(SAT_MAX(N));

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [N:0]    r;
  logic [N-1:0]  mag_b;
  logic          neg_a;
  logic          neg_b;
  logic          a_zero;
  logic          b_zero;
  logic [N-1:0]  res;
  logic          dz;

  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b_in;
  logic [N:0]    r_next;
  logic          q_bit;

  always_comb begin
    mag_a    = A[N-1] ? -A : A;
    mag_b_in = B[N-1] ? -B : B;
  end

  div_paso #(.N(N)) u_paso (
    .r      (r),
    .d_bit  (d[W-1]),
    .mag_b  (mag_b),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      d        <= '0;
      q        <= '0;
      r        <= '0;
      mag_b    <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      a_zero   <= 1'b0;
      b_zero   <= 1'b0;
      res      <= '0;
      dz       <= 1'b0;
      ResulDiv <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            neg_a  <= A[N-1];
            neg_b  <= B[N-1];
            a_zero <= (A == '0);
            b_zero <= (B == '0);
            mag_b  <= mag_b_in;
            d      <= W'(mag_a) << DECIM;
            r      <= '0;
            q      <= '0;
            cnt    <= CW'(W - 1);
            state  <= DIV;
          end
        end
        DIV: begin
          r <= r_next;
          q <= {q[W-2:0], q_bit};
          d <= d << 1;
          if (cnt == '0) begin
            state <= SAT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAT: begin
          dz <= b_zero;
          if (b_zero) begin
            res <= a_zero ? '0 : (neg_a ? SAT_MIN_N : SAT_MAX_N);
          end else if (a_zero) begin
            res <= '0;
          end else if (q > SAT_MAX_W) begin
            res <= (neg_a == neg_b) ? SAT_MAX_N : SAT_MIN_N;
          end else begin
            res <= (neg_a == neg_b) ? q[N-1:0] : -q[N-1:0];
          end
          state <= DONE;
        end
        DONE: begin
          // Outputs update only here so they hold across the next operation.
          ResulDiv <= res;
          div_zero <= dz;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Self-checking bench for divisor_secuencial: DECIM=0 and DECIM=4 instances,
// directed vector table, protocol sequences and randomized model comparison.
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start4;
  logic [11:0] a0, b0, a4, b4;
  logic [11:0] res0, res4;
  logic        done0, busy0, dz0;
  logic        done4, busy4, dz4;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  divisor_secuencial #(.N(12), .DECIM(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0),
    .ResulDiv(res0), .done(done0), .busy(busy0), .div_zero(dz0)
  );

  divisor_secuencial #(.N(12), .DECIM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4),
    .ResulDiv(res4), .done(done4), .busy(busy4), .div_zero(dz4)
  );

  typedef struct {
    int which;
    int a;
    int b;
    int res;
    bit dz;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact rational quotient truncated toward zero, then clamped.
  task automatic ref_div(input int a, input int b, input int decim,
                         output int r, output bit dz);
    longint num, qt;
    dz = (b == 0);
    if (b == 0) begin
      r = (a == 0) ? 0 : ((a > 0) ? 2047 : -2047);
    end else begin
      num = longint'(a) * (longint'(1) << decim);
      qt  = num / longint'(b);
      if (qt > 2047) qt = 2047;
      if (qt < -2047) qt = -2047;
      r = int'(qt);
    end
  endtask

  function automatic int sres(input int which);
    return which != 0 ? int'($signed(res4)) : int'($signed(res0));
  endfunction

  function automatic bit cur_done(input int which);
    return which != 0 ? done4 : done0;
  endfunction

  function automatic bit cur_busy(input int which);
    return which != 0 ? busy4 : busy0;
  endfunction

  function automatic bit cur_dz(input int which);
    return which != 0 ? dz4 : dz0;
  endfunction

  task automatic drive(input int which, input bit s, input int a, input int b);
    if (which != 0) begin
      start4 = s; a4 = 12'(a); b4 = 12'(b);
    end else begin
      start0 = s; a0 = 12'(a); b0 = 12'(b);
    end
  endtask

  task automatic do_op(input int which, input int a, input int b,
                       input int exp_r, input bit exp_dz, input string name);
    int  cycles;
    bit  got;
    @(posedge clk); #1;
    drive(which, 1'b1, a, b);
    @(posedge clk); #1;
    // Operands scrambled after acceptance: the divider must use its captured copy.
    drive(which, 1'b0, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      if (cur_done(which)) got = 1'b1;
    end
    check({name, " latency"}, cycles, which != 0 ? 18 : 14);
    check({name, " result"}, sres(which), exp_r);
    check({name, " div_zero"}, int'(cur_dz(which)), int'(exp_dz));
    check({name, " busy@done"}, int'(cur_busy(which)), 1);
    @(posedge clk); #1;
    check({name, " done pulse"}, int'(cur_done(which)), 0);
    check({name, " busy after"}, int'(cur_busy(which)), 0);
  endtask

  initial begin
    int  ndone;
    int  er;
    bit  edz;
    int  ra, rb, w;

    vecs.push_back('{0,   100,  7,    14, 1'b0});
    vecs.push_back('{0,  -100,  7,   -14, 1'b0});
    vecs.push_back('{0,   100, -7,   -14, 1'b0});
    vecs.push_back('{1,    24,  8,    48, 1'b0});
    vecs.push_back('{1,  2047,  1,  2047, 1'b0});
    vecs.push_back('{0, -2048, -1,  2047, 1'b0});
    vecs.push_back('{0, -2048,  1, -2047, 1'b0});
    vecs.push_back('{0,    -5,  0, -2047, 1'b1});
    vecs.push_back('{0,     0,  0,     0, 1'b1});
    vecs.push_back('{0,     3,  0,  2047, 1'b1});
    vecs.push_back('{0,     0,  5,     0, 1'b0});
    vecs.push_back('{0,    -7,  2,    -3, 1'b0});
    vecs.push_back('{1,   -24,  8,   -48, 1'b0});
    vecs.push_back('{1,     1,  3,     5, 1'b0});
    vecs.push_back('{0,  2047, 2047,   1, 1'b0});

    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset res0", int'(res0), 0);
    check("reset done0", int'(done0), 0);
    check("reset busy0", int'(busy0), 0);
    check("reset dz0", int'(dz0), 0);
    check("reset res4", int'(res4), 0);
    check("reset busy4", int'(busy4), 0);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].which, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz, $sformatf("vec%0d", i));

    // start pulsed again mid-DIV must be ignored
    @(posedge clk); #1;
    drive(0, 1'b1, 100, 7);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    drive(0, 1'b1, 1, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        ndone++;
        check("restart result", sres(0), 14);
      end
    end
    check("restart done count", ndone, 1);

    // Leave nonzero outputs, then abort a run with reset
    do_op(0, 9, 0, 2047, 1'b1, "pre-abort");
    @(posedge clk); #1;
    drive(0, 1'b1, 50, 3);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort res", int'(res0), 0);
    check("abort dz", int'(dz0), 0);
    check("abort busy", int'(busy0), 0);
    check("abort done", int'(done0), 0);
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done0) ndone++;
    end
    check("abort no done", ndone, 0);
    do_op(0, 50, 3, 16, 1'b0, "post-abort");

    // Randomized against the reference model
    for (int k = 0; k < 40; k++) begin
      w  = k % 2;
      ra = int'($urandom_range(0, 4095)) - 2048;
      if (k % 3 == 0) rb = int'($urandom_range(0, 40)) - 20;
      else            rb = int'($urandom_range(0, 4095)) - 2048;
      if (k % 7 == 0) ra = int'($urandom_range(0, 6)) - 3;
      ref_div(ra, rb, w != 0 ? 4 : 0, er, edz);
      do_op(w, ra, rb, er, edz, $sformatf("rnd%0d a=%0d b=%0d", k, ra, rb));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
